servo_sweep: RTL and testbench

SERVO_SWEEP -- requirements
Module: servo_sweep

---
 rtl/servo_sweep.sv | 160 ++++++++++++++++
 tb/tb_servo_sweep.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep.sv
// servo_sweep - steps a servo back and forth between POS_MIN and POS_MAX and
// takes one range measurement at each position.
//
// Each position goes through: wait SETTLE_CYC cycles for the servo to settle,
// request a measurement, wait for meas_done (or time out after TO_CYC cycles),
// then move one step. The sweep reverses at either end of the range.
//
// State table
//   state  | meaning
//   IDLE   | sweep disabled; pos/dir held so a later enable resumes
//   SETTLE | servo moving to pos; counts SETTLE_CYC cycles
//   MEAS   | meas_req high; waits for meas_done or TO_CYC timeout
//   STEP   | one cycle; moves pos by POS_STEP, reversing at the range ends
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   en           in   sweep enable, sampled in IDLE and at the end of STEP
//   meas_done    in   range measurement complete, only honoured in MEAS
//   pos          out  commanded servo position (registered)
//   dir          out  sweep direction, 0 = up, 1 = down
//   meas_req     out  measurement request, high for every MEAS cycle
//   sample_valid out  one-cycle pulse when a measurement completes
//   sample_pos   out  position tagged to the last completed sample
//   meas_to      out  one-cycle pulse when a measurement times out
//   sweep_end    out  one-cycle pulse when the direction reverses
//   busy         out  high in every state except IDLE

module servo_sweep #(
    parameter int POS_LEN    = 8,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 180,
    parameter int POS_STEP   = 1,
    parameter int CNT_LEN    = 24,
    parameter int SETTLE_CYC = 1000000,
    parameter int TO_CYC     = 4000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               meas_done,
    output logic [POS_LEN-1:0] pos,
    output logic               dir,
    output logic               meas_req,
    output logic               sample_valid,
    output logic [POS_LEN-1:0] sample_pos,
    output logic               meas_to,
    output logic               sweep_end,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_MEAS   = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    // Position limits in one extra bit so the up-step compare cannot wrap.
    localparam logic [POS_LEN:0] STEP_W = (POS_LEN+1)'(POS_STEP);
    localparam logic [POS_LEN:0] MAX_W  = (POS_LEN+1)'(POS_MAX);
    localparam logic [POS_LEN:0] LOW_W  = (POS_LEN+1)'(POS_MIN + POS_STEP);
    localparam logic [POS_LEN-1:0] POS_RST = POS_LEN'(POS_MIN);

    localparam logic [CNT_LEN-1:0] SETTLE_LAST = CNT_LEN'(SETTLE_CYC - 1);
    localparam logic [CNT_LEN-1:0] TO_LAST     = CNT_LEN'(TO_CYC - 1);
    localparam logic [CNT_LEN-1:0] CNT_ONE     = CNT_LEN'(1);

    logic [1:0]         state;
    logic [CNT_LEN-1:0] cnt;
    logic [POS_LEN:0]   pos_up;
    logic [POS_LEN-1:0] pos_dn;

    assign pos_up = {1'b0, pos} + STEP_W;
    // Only taken when pos >= POS_MIN+POS_STEP or just after an up-step, so
    // it never goes below zero.
    assign pos_dn = pos - STEP_W[POS_LEN-1:0];

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pos          <= POS_RST;
            dir          <= 1'b0;
            sample_pos   <= POS_RST;
            meas_req     <= 1'b0;
            sample_valid <= 1'b0;
            meas_to      <= 1'b0;
            sweep_end    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            meas_to      <= 1'b0;
            sweep_end    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (en) begin
                        cnt   <= '0;
                        state <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        meas_req <= 1'b1;
                        state    <= S_MEAS;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_MEAS: begin
                    // meas_done is checked first so it wins over a timeout
                    // landing in the same cycle.
                    if (meas_done) begin
                        meas_req     <= 1'b0;
                        sample_valid <= 1'b1;
                        sample_pos   <= pos;
                        state        <= S_STEP;
                    end else if (cnt == TO_LAST) begin
                        meas_req <= 1'b0;
                        meas_to  <= 1'b1;
                        state    <= S_STEP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                S_STEP: begin
                    if (!dir) begin
                        if (pos_up <= MAX_W) begin
                            pos <= pos_up[POS_LEN-1:0];
                        end else begin
                            dir       <= 1'b1;
                            pos       <= pos_dn;
                            sweep_end <= 1'b1;
                        end
                    end else begin
                        if ({1'b0, pos} >= LOW_W) begin
                            pos <= pos_dn;
                        end else begin
                            dir       <= 1'b0;
                            pos       <= pos_up[POS_LEN-1:0];
                            sweep_end <= 1'b1;
                        end
                    end
                    cnt   <= '0;
                    state <= en ? S_SETTLE : S_IDLE;
                end

                default: begin
                    meas_req <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_sweep.sv
// Scoreboard bench for servo_sweep (POS_MIN=0, POS_MAX=4, POS_STEP=2,
// SETTLE_CYC=3, TO_CYC=8). Stimulus pushes expected events (sample, timeout,
// reversal) into a queue; the monitor pops and compares as the DUT emits them.

module tb_servo_sweep;

    localparam int POS_LEN = 8;

    localparam int EV_SAMPLE = 0;
    localparam int EV_TO     = 1;
    localparam int EV_SWEEP  = 2;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               meas_done = 1'b0;
    logic [POS_LEN-1:0] pos;
    logic               dir;
    logic               meas_req;
    logic               sample_valid;
    logic [POS_LEN-1:0] sample_pos;
    logic               meas_to;
    logic               sweep_end;
    logic               busy;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];
    int  resp_k = 0;
    int  req_len = 0;
    int  last_req_len = 0;

    servo_sweep #(
        .POS_LEN(POS_LEN), .POS_MIN(0), .POS_MAX(4), .POS_STEP(2),
        .CNT_LEN(24), .SETTLE_CYC(3), .TO_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .meas_done(meas_done),
        .pos(pos), .dir(dir), .meas_req(meas_req),
        .sample_valid(sample_valid), .sample_pos(sample_pos),
        .meas_to(meas_to), .sweep_end(sweep_end), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    // Measurement responder: meas_done is raised for one cycle in the
    // resp_k-th MEAS cycle; resp_k = 0 means never answer.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            meas_done = 1'b0;
            if (meas_req) begin
                k++;
                if (resp_k != 0 && k == resp_k) meas_done = 1'b1;
            end else begin
                k = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT emits an event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (meas_req) req_len++;
            else if (req_len != 0) begin
                last_req_len = req_len;
                req_len = 0;
            end
            if (sample_valid || meas_to) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result_event", sample_valid ? EV_SAMPLE : EV_TO, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("result_kind", sample_valid ? EV_SAMPLE : EV_TO, e.kind);
                    check("result_pos", sample_valid ? int'(sample_pos) : int'(pos), e.val);
                end
            end
            if (sweep_end) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sweep_end", EV_SWEEP, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("sweep_kind", EV_SWEEP, e.kind);
                    check("sweep_dir", int'(dir), e.val);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("rst_pos", int'(pos), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_meas_req", int'(meas_req), 0);
        check("rst_sample_pos", int'(sample_pos), 0);
        repeat (2) tick();
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tick();

        // Basic stepping and full sweep with two reversals.
        do_reset();
        resp_k = 2;
        push(EV_SAMPLE, 0);
        push(EV_SAMPLE, 2);
        push(EV_SAMPLE, 4);
        push(EV_SWEEP, 1);
        push(EV_SAMPLE, 2);
        push(EV_SAMPLE, 0);
        push(EV_SWEEP, 0);
        push(EV_SAMPLE, 2);
        en = 1'b1;
        n = 0;
        while (!meas_req && n < 20) begin
            tick();
            n++;
        end
        check("meas_req_latency", n, 4);
        wait_drain("sweep_drain", 200);
        en = 1'b0;
        wait_idle("sweep_idle", 20);
        check("sweep_final_pos", int'(pos), 4);
        check("sweep_final_dir", int'(dir), 0);

        // Timeout: no meas_done at all.
        do_reset();
        resp_k = 0;
        push(EV_TO, 0);
        en = 1'b1;
        wait_drain("to_drain", 50);
        en = 1'b0;
        wait_idle("to_idle", 20);
        check("to_req_len", last_req_len, 8);
        check("to_pos", int'(pos), 2);

        // meas_done in the last MEAS cycle beats the timeout.
        do_reset();
        resp_k = 8;
        push(EV_SAMPLE, 0);
        en = 1'b1;
        wait_drain("coll_drain", 50);
        en = 1'b0;
        wait_idle("coll_idle", 20);
        check("coll_pos", int'(pos), 2);

        // Enable dropped during SETTLE at pos 2, then resumed.
        do_reset();
        resp_k = 2;
        push(EV_SAMPLE, 0);
        en = 1'b1;
        wait_drain("drop_first", 50);
        tick();
        en = 1'b0;
        push(EV_SAMPLE, 2);
        wait_drain("drop_completes", 50);
        wait_idle("drop_idle", 20);
        check("drop_pos", int'(pos), 4);
        check("drop_dir", int'(dir), 0);
        repeat (3) tick();
        check("drop_hold_pos", int'(pos), 4);
        push(EV_SAMPLE, 4);
        push(EV_SWEEP, 1);
        push(EV_SAMPLE, 2);
        en = 1'b1;
        wait_drain("resume_drain", 100);
        en = 1'b0;
        wait_idle("resume_idle", 20);
        check("resume_pos", int'(pos), 0);
        check("resume_dir", int'(dir), 1);

        // Asynchronous reset mid-MEAS at pos 2.
        do_reset();
        resp_k = 2;
        push(EV_SAMPLE, 0);
        en = 1'b1;
        wait_drain("arst_first", 50);
        resp_k = 0;
        n = 0;
        while (!meas_req && n < 20) begin
            tick();
            n++;
        end
        check("arst_in_meas", int'(meas_req), 1);
        check("arst_pos_before", int'(pos), 2);
        tick();
        rst = 1'b1;
        #1;
        check("arst_meas_req", int'(meas_req), 0);
        check("arst_pos", int'(pos), 0);
        check("arst_busy", int'(busy), 0);
        en = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_stays_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
